// File: rtl/hazard_forward_ctrl.sv
// Forwarding / hazard controller for a 5-stage MIPS pipeline: registered ForwardA/B selects,
// load-use stall and data-memory freeze sequencing. Define HFC_STATS_EN to enable stall_count.
module hazard_forward_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int STAT_W     = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  id_regwrite,
    input  logic                  id_memread,
    input  logic                  flush,
    input  logic                  dmem_ready,
    output logic                  pc_stall,
    output logic                  ifid_stall,
    output logic                  idex_bubble,
    output logic                  pipe_freeze,
    output logic [1:0]            ForwardA,
    output logic [1:0]            ForwardB,
    output logic [STAT_W-1:0]     stall_count
);

    // Only the fields later stages consult are kept; the WB result is already visible
    // through the register file, so no WB tag is needed for forwarding.
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dest;
        logic                  regwrite;
        logic                  memread;
    } tag_t;

    typedef enum logic [1:0] {RUN, LSTALL, MWAIT} state_t;

    tag_t   ex_reg, mem_reg, ex_next;
    state_t state_reg, state_next, saved_reg, saved_next;
    logic [1:0] forward_a_reg, forward_b_reg, forward_a_next, forward_b_next;
    logic freeze, load_use_raw, load_use, enter_valid;

    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input tag_t ex_t, input tag_t mem_t);
        logic [1:0] sel;
        sel = 2'b00;
        if (ex_t.valid && ex_t.regwrite && !ex_t.memread && ex_t.dest != '0 && ex_t.dest == src)
            sel = 2'b01;
        else if (mem_t.valid && mem_t.regwrite && mem_t.dest != '0 && mem_t.dest == src)
            sel = 2'b10;
        return sel;
    endfunction

    assign freeze       = mem_reg.valid & mem_reg.memread & ~dmem_ready;
    assign load_use_raw = ex_reg.valid & ex_reg.memread & ex_reg.regwrite & (ex_reg.dest != '0)
                        & id_valid & ~flush & ((ex_reg.dest == id_rs) | (ex_reg.dest == id_rt));
    assign load_use     = load_use_raw & ~freeze;
    assign enter_valid  = id_valid & ~flush & ~load_use;

    assign pipe_freeze = freeze;
    assign pc_stall    = freeze | load_use;
    assign ifid_stall  = freeze | load_use;
    assign idex_bubble = load_use;
    assign ForwardA    = forward_a_reg;
    assign ForwardB    = forward_b_reg;

    always_comb begin
        ex_next          = '0;
        forward_a_next   = 2'b00;
        forward_b_next   = 2'b00;
        if (enter_valid) begin
            ex_next.valid    = 1'b1;
            ex_next.dest     = id_dest;
            ex_next.regwrite = id_regwrite;
            ex_next.memread  = id_memread;
            forward_a_next   = fwd_sel(id_rs, ex_reg, mem_reg);
            forward_b_next   = fwd_sel(id_rt, ex_reg, mem_reg);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_reg        <= '0;
            mem_reg       <= '0;
            forward_a_reg <= 2'b00;
            forward_b_reg <= 2'b00;
        end else if (!freeze) begin
            ex_reg        <= ex_next;
            mem_reg       <= ex_reg;
            forward_a_reg <= forward_a_next;
            forward_b_reg <= forward_b_next;
        end
    end

    // MWAIT remembers whether the freeze interrupted a load-use stall.
    always_comb begin
        state_next = state_reg;
        saved_next = saved_reg;
        case (state_reg)
            RUN: begin
                if (freeze) begin
                    state_next = MWAIT;
                    saved_next = RUN;
                end else if (load_use) begin
                    state_next = LSTALL;
                end
            end
            LSTALL: begin
                if (freeze) begin
                    state_next = MWAIT;
                    saved_next = LSTALL;
                end else if (load_use) begin
                    state_next = LSTALL;
                end else begin
                    state_next = RUN;
                end
            end
            MWAIT: begin
                if (dmem_ready)
                    state_next = load_use ? LSTALL : saved_reg;
            end
            default: state_next = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= RUN;
            saved_reg <= RUN;
        end else begin
            state_reg <= state_next;
            saved_reg <= saved_next;
        end
    end

`ifdef HFC_STATS_EN
    logic [STAT_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_reg <= '0;
        else if (pc_stall && count_reg != '1)
            count_reg <= count_reg + 1'b1;
    end

    assign stall_count = count_reg;
`else
    assign stall_count = '0;
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Scoreboard bench for hazard_forward_ctrl: a program-level pipeline model predicts each
// cycle's outputs; a negedge monitor pops and compares them against the DUT.
module tb_hazard_forward_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic id_valid = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0, dmem_ready = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
    logic pc_stall, ifid_stall, idex_bubble, pipe_freeze;
    logic [1:0] ForwardA, ForwardB;
    logic [15:0] stall_count;

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.REG_ADDR_W(5), .STAT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .flush(flush), .dmem_ready(dmem_ready), .pc_stall(pc_stall), .ifid_stall(ifid_stall),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze), .ForwardA(ForwardA),
        .ForwardB(ForwardB), .stall_count(stall_count)
    );

    typedef struct packed {
        logic       valid;
        logic [4:0] rs, rt, dest;
        logic       regwrite, memread;
        logic       fl;
        logic [2:0] lat;
    } ins_t;

    typedef struct packed {
        logic        frz, pc, ifid, bub;
        logic [1:0]  fa, fb;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    ins_t prog[$];

    // Reference model: instructions sitting in EX and MEM plus the selects the DUT should show.
    ins_t m_ex, m_mem, cur;
    logic [1:0] m_fa, m_fb;
    int m_cnt, wait_left, cyc;
    bit hold, in_reset, last_freeze;
    int n_cmp = 0, n_bad = 0;

    function automatic ins_t mk(bit v, int rs, int rt, int dest, bit rw, bit mr, bit fl, int lat);
        ins_t i;
        i.valid = v; i.rs = 5'(rs); i.rt = 5'(rt); i.dest = 5'(dest);
        i.regwrite = rw; i.memread = mr; i.fl = fl; i.lat = 3'(lat);
        return i;
    endfunction

    function automatic ins_t rand_ins();
        bit mr;
        mr = ($urandom_range(0, 9) < 3);
        return mk($urandom_range(0, 9) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), mr | ($urandom_range(0, 4) != 0), mr,
                  $urandom_range(0, 9) == 0, $urandom_range(0, 3));
    endfunction

    // Source of an operand: the newest older instruction producing it, $0 never forwarded.
    function automatic logic [1:0] src_sel(logic [4:0] x);
        if (x == 0) return 2'b00;
        if (m_ex.valid && m_ex.regwrite && !m_ex.memread && m_ex.dest == x) return 2'b01;
        if (m_mem.valid && m_mem.regwrite && m_mem.dest == x) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_ex = '0; m_mem = '0; m_fa = 2'b00; m_fb = 2'b00;
        m_cnt = 0; wait_left = 0; hold = 0;
    endtask

    // mode: 0 normal, 1 assert reset mid-cycle, 2 release reset
    task automatic cycle(input int mode);
        bit rdy, frz, lu, enter;
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (!hold) cur = (prog.size() > 0) ? prog.pop_front() : rand_ins();
        id_valid = cur.valid; id_rs = cur.rs; id_rt = cur.rt; id_dest = cur.dest;
        id_regwrite = cur.regwrite; id_memread = cur.memread; flush = cur.fl;
        if (m_mem.valid && m_mem.memread) rdy = (wait_left == 0);
        else rdy = 1'($urandom_range(0, 1));
        dmem_ready = rdy;
        if (mode == 1) begin
            rst_n = 1'b0; in_reset = 1; model_reset();
        end else if (mode == 2) begin
            rst_n = 1'b1; in_reset = 0;
        end
        frz = m_mem.valid && m_mem.memread && !rdy;
        lu  = !frz && m_ex.valid && m_ex.memread && m_ex.regwrite && m_ex.dest != 0 &&
              cur.valid && !cur.fl && (m_ex.dest == cur.rs || m_ex.dest == cur.rt);
        e.frz = frz; e.pc = frz | lu; e.ifid = frz | lu; e.bub = lu;
        e.fa = m_fa; e.fb = m_fb;
`ifdef HFC_STATS_EN
        e.cnt = 16'(m_cnt);
`else
        e.cnt = 16'd0;
`endif
        sb_q.push_back(e);
        last_freeze = frz;
        if (in_reset || mode == 2) begin
            if (mode != 2) return;
        end
        if (frz || lu) m_cnt = (m_cnt == 65535) ? 65535 : m_cnt + 1;
        hold = frz || lu;
        if (frz) begin
            if (wait_left > 0) wait_left--;
        end else begin
            enter = cur.valid && !cur.fl && !lu;
            m_fa  = enter ? src_sel(cur.rs) : 2'b00;
            m_fb  = enter ? src_sel(cur.rt) : 2'b00;
            m_mem = m_ex;
            m_ex  = enter ? cur : '0;
            wait_left = (m_mem.valid && m_mem.memread) ? int'(m_mem.lat) : 0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, expv);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("pipe_freeze", 32'(pipe_freeze), 32'(e.frz));
                chk("pc_stall",    32'(pc_stall),    32'(e.pc));
                chk("ifid_stall",  32'(ifid_stall),  32'(e.ifid));
                chk("idex_bubble", 32'(idex_bubble), 32'(e.bub));
                chk("ForwardA",    32'(ForwardA),    32'(e.fa));
                chk("ForwardB",    32'(ForwardB),    32'(e.fb));
                chk("stall_count", 32'(stall_count), 32'(e.cnt));
                $display("cycle %0d: frz=%0b pc=%0b bub=%0b fa=%0d fb=%0d cnt=%0d",
                         cyc, pipe_freeze, pc_stall, idex_bubble, ForwardA, ForwardB, stall_count);
            end
        end
    end

    initial begin
        int guard;
        cyc = 0; in_reset = 1; last_freeze = 0;
        model_reset();
        cur = mk(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) cycle(1);
        cycle(2);
        // forwarding from EX, then from MEM
        prog.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0));
        prog.push_back(mk(1, 3, 4, 7, 1, 0, 0, 0));
        prog.push_back(mk(1, 1, 2, 3, 1, 0, 0, 0));
        prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        prog.push_back(mk(1, 4, 3, 6, 1, 0, 0, 0));
        // load-use, then a load that waits three cycles in MEM
        prog.push_back(mk(1, 1, 1, 5, 1, 1, 0, 0));
        prog.push_back(mk(1, 5, 2, 8, 1, 0, 0, 0));
        prog.push_back(mk(1, 1, 1, 6, 1, 1, 0, 3));
        prog.push_back(mk(1, 1, 2, 9, 1, 0, 0, 0));
        prog.push_back(mk(1, 3, 2, 10, 1, 0, 0, 0));
        // $0 is never forwarded; a flushed dependent of a load never stalls
        prog.push_back(mk(1, 1, 2, 0, 1, 0, 0, 0));
        prog.push_back(mk(1, 0, 0, 11, 1, 0, 0, 0));
        prog.push_back(mk(1, 1, 1, 5, 1, 1, 0, 0));
        prog.push_back(mk(1, 5, 5, 12, 1, 0, 1, 0));
        repeat (4) prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        while (prog.size() > 0) cycle(0);
        // reset while frozen
        prog.push_back(mk(1, 1, 1, 7, 1, 1, 0, 4));
        repeat (6) prog.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
        guard = 0;
        while (!last_freeze && guard < 20) begin
            cycle(0);
            guard++;
        end
        chk("freeze_reached", 32'(last_freeze), 32'd1);
        cycle(1);
        cycle(1);
        prog.delete();
        cycle(2);
        repeat (1500) cycle(0);
        guard = 0;
        while (sb_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
